mips_ex_alu_arb: RTL and testbench
==================================

Name: mips_ex_alu_arb

Overview:
- Arbiter and sequencer for the shared EX-stage ALU datapath. Three requesters compete for the single combinational datapath: regular ALU, AGU and BJP.
- Each cycle the block issues a one-hot grant that drives the datapath requester-select inputs.
- It captures the datapath result into a one-entry response register and returns it with a source tag under valid/ready backpressure.
- Sits between the EX issue logic and the datapath; the operands and op-selects pass straight from requesters to the datapath.

Parameters:
- DATA_WIDTH, `MIPS_DATA_WIDTH: width of the datapath result and of the response data.
- NUM_REQ, 3: number of requesters; fixed at 3; bit order is alu=0, agu=1, bjp=2.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- alu_req_valid  input  1  regular ALU requester has an op pending.
- alu_req_ready  output  1  regular ALU op accepted this cycle.
- agu_req_valid  input  1  AGU requester has an op pending.
- agu_req_ready  output  1  AGU op accepted this cycle.
- bjp_req_valid  input  1  BJP requester has an op pending.
- bjp_req_ready  output  1  BJP op accepted this cycle.
- alu_req_alu  output  1  datapath select for regular ALU (the grant).
- agu_req_alu  output  1  datapath select for AGU (the grant).
- bjp_req_alu  output  1  datapath select for BJP (the grant).
- dpath_res  input  DATA_WIDTH  datapath result for the granted op, same cycle.
- dpath_cmp_res  input  1  datapath branch-compare result, same cycle.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_src  output  3  one-hot source tag of the response.
- rsp_res  output  DATA_WIDTH  registered result.
- rsp_cmp  output  1  registered compare result; meaningful only when rsp_src is bjp.

Behaviour:
- Reset (async assert, sync deassert use): rsp_valid=0, rsp_src=3'b000, rsp_res=0, rsp_cmp=0. Priority pointer resets to bjp. All grants are combinationally 0 while no request is valid.
- slot_free = ~rsp_valid | rsp_ready.
- Grant: when slot_free=1 and at least one req_valid=1, exactly one grant asserts, chosen by the priority rule. When slot_free=0, every grant and every req_ready is 0.
- Grant is combinational from valids, pointer and slot_free; there are no registered grants.
- req_ready equals that requester's grant. A handshake is req_valid & req_ready.
- The grant/datapath-select vector is one-hot or zero; it must never be multi-hot. The datapath ORs the selected operands, so multi-hot would corrupt the result.
- Latency: op granted in cycle N → rsp_valid=1 in cycle N+1, with rsp_res=dpath_res and rsp_cmp=dpath_cmp_res sampled at the N edge, and rsp_src=grant.
- Throughput: one op/cycle with rsp_ready held at 1.
- Response register update:
  - Handshake this cycle: load it.
  - Else if rsp_ready: clear rsp_valid. rsp_src, rsp_res and rsp_cmp hold their old values (not cleared).
  - Else: hold.
- Simultaneous drain and grant in the same cycle: the old response leaves and the new one loads. No bubble, no loss.
- Fixed-priority rule (default): bjp > agu > alu. The pointer is unused.
- Requesters must hold req_valid and their operands stable until ready. The arbiter does not check this.
- Reset mid-operation: a pending response is discarded; requesters re-present after reset.

Optional Feature:
- Macro: MIPS_EX_ALU_ARB_RR_EN.
- Defined: round-robin.
  - Pointer marks the highest-priority requester; rotation order is bjp→agu→alu→bjp.
  - After a grant to requester k, the pointer moves to the requester after k.
  - The pointer updates only on a handshake; it holds during stalls and idle cycles.
- Undefined: fixed priority bjp > agu > alu. The pointer register is not instantiated.

Decomposition:
- Shared define file gets:
  - `MIPS_EX_ALU_SRC_ALU = 3'b001
  - `MIPS_EX_ALU_SRC_AGU = 3'b010
  - `MIPS_EX_ALU_SRC_BJP = 3'b100
  - `MIPS_EX_ALU_NUM_REQ = 3
- One sub-module: mips_ex_alu_arb_pick. It is combinational. Inputs are the 3-bit valid vector, the 3-bit one-hot pointer and an enable (slot_free); output is the one-hot grant. Fixed mode ties the pointer to bjp.
- Response register and pointer live in the top module.

Test Plan:
- Reset, then alu/agu/bjp valid = 1/1/1 with rsp_ready=1. Fixed mode: grants bjp, bjp, bjp… each cycle. rsp_src=3'b100 from cycle 1.
- agu valid alone with dpath_res=32'h0000_1234: agu_req_ready=1 in cycle 0. Cycle 1: rsp_valid=1, rsp_src=3'b010, rsp_res=32'h0000_1234.
- rsp_ready=0 with a response pending and alu valid: all readies 0 and rsp_res held for 5 cycles. Raise rsp_ready: alu is granted in that same cycle, and its result appears the next cycle with no bubble.
- bjp valid with dpath_cmp_res=1, then alu valid with dpath_cmp_res=0: rsp_cmp is 1 then 0. rsp_src is 3'b100 then 3'b001.
- MIPS_EX_ALU_ARB_RR_EN, all three valid continuously, rsp_ready=1: grant order bjp, agu, alu, bjp, agu, alu. A 2-cycle rsp_ready=0 stall mid-sequence does not skip any requester.
- Assert rst_n=0 asynchronously while rsp_valid=1: rsp_valid drops before the next clk edge. After release with no valids: rsp_valid=0 and no grants.

Source files
------------

// File: rtl/mips_ex_alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// mips_ex_alu_arb_pkg
// Shared definitions for the EX-stage ALU arbiter: datapath width, requester
// source tags (one-hot, alu=bit0, agu=bit1, bjp=bit2), requester indices and
// small helpers used by the priority picker and the round-robin pointer.
// Optional feature macro used by this slice: MIPS_EX_ALU_ARB_RR_EN.
// ---------------------------------------------------------------------------
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_EX_ALU_SRC_ALU
`define MIPS_EX_ALU_SRC_ALU 3'b001
`endif
`ifndef MIPS_EX_ALU_SRC_AGU
`define MIPS_EX_ALU_SRC_AGU 3'b010
`endif
`ifndef MIPS_EX_ALU_SRC_BJP
`define MIPS_EX_ALU_SRC_BJP 3'b100
`endif
`ifndef MIPS_EX_ALU_NUM_REQ
`define MIPS_EX_ALU_NUM_REQ 3
`endif

package mips_ex_alu_arb_pkg;

    localparam int DATA_W  = `MIPS_DATA_WIDTH;
    localparam int NUM_REQ = `MIPS_EX_ALU_NUM_REQ;

    localparam logic [NUM_REQ-1:0] SRC_ALU = `MIPS_EX_ALU_SRC_ALU;
    localparam logic [NUM_REQ-1:0] SRC_AGU = `MIPS_EX_ALU_SRC_AGU;
    localparam logic [NUM_REQ-1:0] SRC_BJP = `MIPS_EX_ALU_SRC_BJP;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_AGU = 2'd1,
        REQ_BJP = 2'd2
    } req_idx_e;

    // One-hot of the first valid requester in the order p0, p1, p2.
    function automatic logic [NUM_REQ-1:0] pick_first(
        input logic [NUM_REQ-1:0] valid,
        input req_idx_e           p0,
        input req_idx_e           p1,
        input req_idx_e           p2
    );
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (valid[p0])      g[p0] = 1'b1;
        else if (valid[p1]) g[p1] = 1'b1;
        else if (valid[p2]) g[p2] = 1'b1;
        return g;
    endfunction

    // Rotation order is bjp -> agu -> alu -> bjp: the requester after a
    // granted one becomes the new highest priority.
    function automatic logic [NUM_REQ-1:0] next_ptr(input logic [NUM_REQ-1:0] grant);
        return {grant[0], grant[2], grant[1]};
    endfunction

endpackage

// File: rtl/mips_ex_alu_arb_pick.sv
// ---------------------------------------------------------------------------
// mips_ex_alu_arb_pick
// Combinational one-hot picker. The pointer names the highest-priority
// requester; the rest follow in rotation order bjp -> agu -> alu -> bjp.
// With the pointer tied to bjp this is fixed priority bjp > agu > alu.
// Ports:
//   valid [2:0] in  - request valids (alu=0, agu=1, bjp=2)
//   ptr   [2:0] in  - one-hot highest-priority requester
//   en          in  - response slot free; no grant when low
//   grant [2:0] out - one-hot or zero grant
// ---------------------------------------------------------------------------
module mips_ex_alu_arb_pick
    import mips_ex_alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = '0;
        if (en) begin
            case (ptr)
                SRC_ALU: grant = pick_first(valid, REQ_ALU, REQ_BJP, REQ_AGU);
                SRC_AGU: grant = pick_first(valid, REQ_AGU, REQ_ALU, REQ_BJP);
                default: grant = pick_first(valid, REQ_BJP, REQ_AGU, REQ_ALU);
            endcase
        end
    end

endmodule

// File: rtl/mips_ex_alu_arb.sv
// ---------------------------------------------------------------------------
// mips_ex_alu_arb
// Arbiter/sequencer for the shared EX-stage ALU datapath. Issues a one-hot
// grant (also the datapath requester-select) to one of alu/agu/bjp, captures
// the same-cycle datapath result into a one-entry response register and
// returns it with a one-hot source tag under valid/ready backpressure.
// Build option: define MIPS_EX_ALU_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority bjp > agu > alu with no pointer register.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   {alu,agu,bjp}_req_valid  in   - requester has an op pending
//   {alu,agu,bjp}_req_ready  out  - op accepted this cycle (= grant)
//   {alu,agu,bjp}_req_alu    out  - datapath select (= grant)
//   dpath_res, dpath_cmp_res in   - datapath result for granted op
//   rsp_valid/rsp_ready           - response handshake
//   rsp_src, rsp_res, rsp_cmp out - registered tag, result, compare
// ---------------------------------------------------------------------------
module mips_ex_alu_arb
    import mips_ex_alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_req_valid,
    output logic                  alu_req_ready,
    input  logic                  agu_req_valid,
    output logic                  agu_req_ready,
    input  logic                  bjp_req_valid,
    output logic                  bjp_req_ready,
    output logic                  alu_req_alu,
    output logic                  agu_req_alu,
    output logic                  bjp_req_alu,
    input  logic [DATA_WIDTH-1:0] dpath_res,
    input  logic                  dpath_cmp_res,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [NUM_REQ-1:0]    rsp_src,
    output logic [DATA_WIDTH-1:0] rsp_res,
    output logic                  rsp_cmp
);

    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ptr;
    logic               slot_free;
    logic               hs;

    assign valid     = {bjp_req_valid, agu_req_valid, alu_req_valid};
    // The slot is free when empty or when the current response leaves this
    // cycle, which lets drain and reload happen together with no bubble.
    assign slot_free = ~rsp_valid | rsp_ready;
    // The picker only grants valid requesters, so any grant is a handshake.
    assign hs        = |grant;

`ifdef MIPS_EX_ALU_ARB_RR_EN
    logic [NUM_REQ-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SRC_BJP;
        end else if (hs) begin
            // NOTE: non-blocking for all clocked state so every register sees
            // pre-edge values regardless of statement order.
            ptr_q <= next_ptr(grant);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = SRC_BJP;
`endif

    mips_ex_alu_arb_pick u_pick (
        .valid (valid),
        .ptr   (ptr),
        .en    (slot_free),
        .grant (grant)
    );

    assign alu_req_alu   = grant[REQ_ALU];
    assign agu_req_alu   = grant[REQ_AGU];
    assign bjp_req_alu   = grant[REQ_BJP];
    assign alu_req_ready = grant[REQ_ALU];
    assign agu_req_ready = grant[REQ_AGU];
    assign bjp_req_ready = grant[REQ_BJP];

    // Response register. On a plain drain only the valid bit clears; the
    // payload keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: a single-entry register, so the payload is reset too; a
            // deeper storage array would reset only its valid bits.
            rsp_valid <= 1'b0;
            rsp_src   <= '0;
            rsp_res   <= '0;
            rsp_cmp   <= 1'b0;
        end else if (hs) begin
            rsp_valid <= 1'b1;
            rsp_src   <= grant;
            rsp_res   <= dpath_res;
            rsp_cmp   <= dpath_cmp_res;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_ex_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_mips_ex_alu_arb
// Directed bench for mips_ex_alu_arb. Expected grants come from a small
// reference picker; expected responses are queued when an op is granted and
// popped when the response register should have loaded it.
// Works in both builds (MIPS_EX_ALU_ARB_RR_EN defined or not).
// ---------------------------------------------------------------------------
module tb_mips_ex_alu_arb;

    localparam int DW = mips_ex_alu_arb_pkg::DATA_W;

    typedef struct packed {
        logic [2:0]    src;
        logic [DW-1:0] res;
        logic          cmp;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_req_valid, agu_req_valid, bjp_req_valid;
    logic          alu_req_ready, agu_req_ready, bjp_req_ready;
    logic          alu_req_alu, agu_req_alu, bjp_req_alu;
    logic [DW-1:0] dpath_res;
    logic          dpath_cmp_res;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_src;
    logic [DW-1:0] rsp_res;
    logic          rsp_cmp;

    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t sb[$];
    rsp_t m_last;
    logic m_valid;
    logic [2:0] m_ptr;

    always #5 clk = ~clk;

    mips_ex_alu_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_req_valid (alu_req_valid),
        .alu_req_ready (alu_req_ready),
        .agu_req_valid (agu_req_valid),
        .agu_req_ready (agu_req_ready),
        .bjp_req_valid (bjp_req_valid),
        .bjp_req_ready (bjp_req_ready),
        .alu_req_alu   (alu_req_alu),
        .agu_req_alu   (agu_req_alu),
        .bjp_req_alu   (bjp_req_alu),
        .dpath_res     (dpath_res),
        .dpath_cmp_res (dpath_cmp_res),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_src       (rsp_src),
        .rsp_res       (rsp_res),
        .rsp_cmp       (rsp_cmp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference picker: walk from the pointer in order bjp, agu, alu, bjp.
    function automatic logic [2:0] model_pick(input logic [2:0] v, input logic [2:0] p);
        int start;
        int idx;
        start = p[0] ? 0 : (p[1] ? 1 : 2);
        for (int k = 0; k < 3; k++) begin
            idx = (start + 3 - k) % 3;
            if (v[idx]) return 3'b001 << idx;
        end
        return 3'b000;
    endfunction

    function automatic logic [2:0] model_next(input logic [2:0] g);
        if (g == 3'b100) return 3'b010;
        if (g == 3'b010) return 3'b001;
        return 3'b100;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = '0;
        m_ptr   = 3'b100;
        sb.delete();
    endtask

    task automatic check_rsp(input string tag);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
        check({tag, ".rsp_src"},   64'(rsp_src),   64'(m_last.src));
        check({tag, ".rsp_res"},   64'(rsp_res),   64'(m_last.res));
        check({tag, ".rsp_cmp"},   64'(rsp_cmp),   64'(m_last.cmp));
    endtask

    // One cycle: drive inputs, check combinational grant/ready, clock,
    // check the response register.
    task automatic step(input string tag, input logic [2:0] v, input logic [DW-1:0] dres,
                        input logic dcmp, input logic rdy);
        logic [2:0] eg;
        rsp_t       e;
        {bjp_req_valid, agu_req_valid, alu_req_valid} = v;
        dpath_res     = dres;
        dpath_cmp_res = dcmp;
        rsp_ready     = rdy;
        #1;
        eg = (!m_valid || rdy) ? model_pick(v, m_ptr) : 3'b000;
        check({tag, ".grant"}, 64'({bjp_req_alu, agu_req_alu, alu_req_alu}), 64'(eg));
        check({tag, ".ready"}, 64'({bjp_req_ready, agu_req_ready, alu_req_ready}), 64'(eg));
        if (eg != 3'b000) begin
            e.src = eg;
            e.res = dres;
            e.cmp = dcmp;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (eg != 3'b000) begin
            m_valid = 1'b1;
`ifdef MIPS_EX_ALU_ARB_RR_EN
            m_ptr = model_next(eg);
`endif
            m_last = sb.pop_front();
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        check_rsp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {alu_req_valid, agu_req_valid, bjp_req_valid} = 3'b000;
        dpath_res     = '0;
        dpath_cmp_res = 1'b0;
        rsp_ready     = 1'b0;
        model_reset();
        #1;
        check_rsp("reset");
        check("reset.grant", 64'({bjp_req_alu, agu_req_alu, alu_req_alu}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All three valid, consumer always ready.
        step("all0", 3'b111, 32'hA000_0001, 1'b0, 1'b1);
        step("all1", 3'b111, 32'hA000_0002, 1'b1, 1'b1);
        step("all2", 3'b111, 32'hA000_0003, 1'b0, 1'b1);
        step("all3", 3'b111, 32'hA000_0004, 1'b0, 1'b1);

        // AGU alone.
        step("agu", 3'b010, 32'h0000_1234, 1'b0, 1'b1);
        step("idle0", 3'b000, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // Backpressure: load, then stall 5 cycles with alu pending.
        step("ld", 3'b100, 32'h5555_AAAA, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("stall", 3'b001, 32'h0BAD_0000 + DW'(i), 1'b0, 1'b0);
        step("unstall", 3'b001, 32'h0000_0A1A, 1'b0, 1'b1);

        // Compare result tagging.
        step("cmp_bjp", 3'b100, 32'h0000_00B1, 1'b1, 1'b1);
        step("cmp_alu", 3'b001, 32'h0000_00A1, 1'b0, 1'b1);

        // Drain leaves payload in place; empty slot grants even with rsp_ready low.
        step("drain", 3'b000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        step("empty_rdy0", 3'b011, 32'h0000_0C0C, 1'b1, 1'b0);
        step("full_rdy0", 3'b011, 32'h0000_0D0D, 1'b0, 1'b0);
        step("release", 3'b011, 32'h0000_0E0E, 1'b0, 1'b1);

        // Continuous contention with a 2-cycle stall in the middle.
        for (int i = 0; i < 3; i++) step("rr_a", 3'b111, 32'h0000_7000 + DW'(i), i[0], 1'b1);
        step("rr_s0", 3'b111, 32'h0000_7100, 1'b0, 1'b0);
        step("rr_s1", 3'b111, 32'h0000_7101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("rr_b", 3'b111, 32'h0000_7200 + DW'(i), i[1], 1'b1);

        // Async reset while a response is pending.
        step("pre_rst", 3'b010, 32'h0000_9999, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_rsp("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 3'b000, 32'h0000_1111, 1'b0, 1'b1);
        step("post_rst_agu", 3'b011, 32'h0000_2222, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
